// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the core
// load/store port (C) and the debug/loader port (D).
//
// Each accepted request becomes one registered memory command. The arbiter
// waits out the memory latency and then pulses the owner's done for one cycle,
// updating the owner's read data on loads. Ties go round-robin.
//
// Ports
//   clk, reset            clock, async active-high reset
//   c_req/c_we/c_addr/c_wdata -> c_gnt/c_done/c_rdata   core port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_done/d_rdata   debug/loader port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata          memory side
//   busy                  sequencer is not in IDLE
//
// state | meaning
// IDLE  | no access in flight; grants may be issued
// ISSUE | mem_en high, registered command presented to memory
// WAIT  | waiting for mem_rdata; last WAIT cycle is the data-valid cycle
// RESP  | owner's done pulses; load data captured on entry
module dmem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1     // 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // WAIT lasts MEM_LAT cycles: the counter starts at MEM_LAT-1 and the
    // cycle in which it reads zero is the one where mem_rdata is valid.
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_d;     // 1: last grant went to D
    logic        owner_d;    // 1: access in flight belongs to D
    logic        we_q;
    logic [3:0]  lat_cnt;

    always_comb begin
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (c_req && (!d_req || last_d)) begin
                    c_gnt = 1'b1;
                end else if (d_req) begin
                    d_gnt = 1'b1;
                end
                if (c_gnt || d_gnt) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (lat_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_en = (state == ISSUE);
    assign mem_we = we_q & mem_en;
    assign busy   = (state != IDLE);
    assign c_done = (state == RESP) && !owner_d;
    assign d_done = (state == RESP) && owner_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            owner_d   <= 1'b0;
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_cnt   <= 4'd0;
            c_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state <= state_nxt;

            if (c_gnt || d_gnt) begin
                last_d    <= d_gnt;
                owner_d   <= d_gnt;
                we_q      <= d_gnt ? d_we    : c_we;
                mem_addr  <= d_gnt ? d_addr  : c_addr;
                mem_wdata <= d_gnt ? d_wdata : c_wdata;
            end

            if (state == ISSUE) begin
                lat_cnt <= LAT_LOAD;
            end else if (state == WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            // capture on the WAIT->RESP edge; stores leave rdata untouched
            if (state == WAIT && lat_cnt == 4'd0 && !we_q) begin
                if (owner_d) begin
                    d_rdata <= mem_rdata;
                end else begin
                    c_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;

    // instance with MEM_LAT=1
    logic        c_req, c_we, d_req, d_we;
    logic [7:0]  c_addr, d_addr;
    logic [63:0] c_wdata, d_wdata;
    logic        c_gnt, c_done, d_gnt, d_done;
    logic [63:0] c_rdata, d_rdata;
    logic        mem_en, mem_we, busy;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    // instance with MEM_LAT=3 (port C tied off)
    logic        d3_req, d3_we;
    logic [7:0]  d3_addr;
    logic        c3_gnt, c3_done, d3_gnt, d3_done;
    logic [63:0] c3_rdata, d3_rdata;
    logic        mem3_en, mem3_we, busy3;
    logic [7:0]  mem3_addr;
    logic [63:0] mem3_wdata, mem3_rdata;

    logic [63:0] mem1 [256];
    logic [63:0] mem3 [256];
    logic [63:0] rd1;
    logic [63:0] p3 [3];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset),
        .c_req(1'b0), .c_we(1'b0), .c_addr(8'h00), .c_wdata(64'h0),
        .c_gnt(c3_gnt), .c_done(c3_done), .c_rdata(c3_rdata),
        .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(64'h0),
        .d_gnt(d3_gnt), .d_done(d3_done), .d_rdata(d3_rdata),
        .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr),
        .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory models: data valid MEM_LAT cycles after the mem_en cycle
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            rd1 <= mem1[mem_addr];
        end
    end
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        if (mem3_en && mem3_we) mem3[mem3_addr] <= mem3_wdata;
        p3[0] <= mem3_en ? mem3[mem3_addr] : 64'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem3_rdata = p3[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 64'h0;
            mem3[i] = 64'h0;
        end
        mem1[8]  = 64'hDEAD_BEEF;
        mem3[40] = 64'h1234_5678_9ABC_DEF0;
        rd1 = 64'h0;
        for (int i = 0; i < 3; i++) p3[i] = 64'h0;

        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d3_req = 0; d3_we = 0; d3_addr = 0;
        reset = 0;
        #1 reset = 1;
        cyc();
        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_done", {c_done, d_done, c_gnt, d_gnt}, 0);
        chk("rst_busy3", busy3, 0);
        reset = 0;
        cyc();

        // single C load of addr 8
        c_req = 1; c_we = 0; c_addr = 8;
        #1 chk("a_c_gnt", c_gnt, 1);
        chk("a_d_gnt", d_gnt, 0);
        cyc();
        chk("a_mem_en", mem_en, 1);
        chk("a_mem_addr", mem_addr, 8);
        chk("a_mem_we", mem_we, 0);
        chk("a_busy", busy, 1);
        chk("a_no_gnt_busy", c_gnt, 0);
        c_req = 0;
        cyc();
        chk("a_mem_en_off", mem_en, 0);
        chk("a_c_done_early", c_done, 0);
        cyc();
        chk("a_c_done", c_done, 1);
        chk("a_c_rdata", c_rdata, 64'hDEAD_BEEF);
        chk("a_d_done", d_done, 0);
        cyc();
        chk("a_c_done_off", c_done, 0);
        chk("a_busy_off", busy, 0);

        // C load, reset asserted in WAIT
        c_req = 1; c_we = 0; c_addr = 8;
        #1 chk("e_c_gnt", c_gnt, 1);
        cyc();
        c_req = 0;
        cyc();
        chk("e_busy_wait", busy, 1);
        reset = 1;
        #1;
        chk("e_busy", busy, 0);
        chk("e_mem_addr", mem_addr, 0);
        chk("e_mem_en", mem_en, 0);
        chk("e_c_rdata", c_rdata, 0);
        chk("e_done", c_done, 0);
        cyc();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("e_no_done", c_done, 0);
        end

        // both request stores continuously: C first, then strict alternation
        c_req = 1; c_we = 1; c_addr = 0;  c_wdata = 64'h11;
        d_req = 1; d_we = 1; d_addr = 16; d_wdata = 64'h22;
        #1;
        for (int k = 0; k < 12; k++) begin
            chk("b_c_gnt", c_gnt, (k % 4 == 0) && ((k / 4) % 2 == 0));
            chk("b_d_gnt", d_gnt, (k % 4 == 0) && ((k / 4) % 2 == 1));
            chk("b_one_hot", c_gnt & d_gnt, 0);
            cyc();
        end
        c_req = 0; d_req = 0;
        #1 chk("b_withdraw", c_gnt | d_gnt, 0);
        cyc();

        // D store of 42 to addr 24; C request withdrawn while D busy
        d_req = 1; d_we = 1; d_addr = 24; d_wdata = 64'd42;
        #1 chk("c_d_gnt", d_gnt, 1);
        chk("c_c_gnt", c_gnt, 0);
        cyc();
        chk("c_mem_en", mem_en, 1);
        chk("c_mem_we", mem_we, 1);
        chk("c_mem_addr", mem_addr, 24);
        chk("c_mem_wdata", mem_wdata, 64'd42);
        d_req = 0;
        cyc();
        chk("c_mem_we_off", mem_we, 0);
        c_req = 1; c_we = 0; c_addr = 8'h63;
        #1 chk("f_c_gnt_wait", c_gnt, 0);
        cyc();
        chk("c_d_done", d_done, 1);
        chk("f_c_gnt_resp", c_gnt, 0);
        c_req = 0;
        cyc();
        chk("f_c_gnt_idle", c_gnt, 0);
        chk("f_busy", busy, 0);
        cyc();
        chk("f_mem_en", mem_en, 0);
        cyc();
        chk("f_c_done", c_done, 0);

        // C load of addr 24 returns the stored 42
        c_req = 1; c_we = 0; c_addr = 24;
        #1 chk("c2_c_gnt", c_gnt, 1);
        cyc();
        c_req = 0;
        cyc();
        cyc();
        chk("c2_c_done", c_done, 1);
        chk("c2_c_rdata", c_rdata, 64'd42);
        chk("c2_d_rdata", d_rdata, 0);
        cyc();

        // MEM_LAT=3 D load of addr 40
        d3_req = 1; d3_we = 0; d3_addr = 40;
        #1 chk("d_gnt3", d3_gnt, 1);
        chk("d_busy3_t", busy3, 0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            if (k == 1) d3_req = 0;
            chk("d_done3", d3_done, k == 5);
            chk("d_busy3", busy3, (k >= 1) && (k <= 5));
            if (k == 5) chk("d_rdata3", d3_rdata, 64'h1234_5678_9ABC_DEF0);
        end
        chk("d_c3_done", c3_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
